// File: rtl/pll_reset_sequencer.sv
// Staged system-reset sequencer driven by PLL lock: synchronises locked, waits for a
// stable-lock window, releases reset domains in ascending order and tracks lock losses.
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGES        = 3,
  parameter int STAGE_GAP     = 16,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  global_clock,
  input  logic                  reset,
  input  logic                  locked,
  input  logic                  clear_sticky,
  output logic [STAGES-1:0]     sys_reset,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic                  lock_lost_sticky
);

  localparam int STABLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int GAP_W    = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    HOLD,
    STABILIZE,
    RELEASE,
    RUN
  } state_t;

  state_t                state_q, state_d;
  logic                  locked_meta_q, locked_s_q;
  logic [STABLE_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [STAGES-1:0]     sys_reset_q, sys_reset_d;
  logic                  ready_q, ready_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  sticky_q, sticky_d;
  logic                  release_stage;
  logic                  lock_loss;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    stable_cnt_d  = stable_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    sys_reset_d   = sys_reset_q;
    ready_d       = ready_q;
    loss_cnt_d    = loss_cnt_q;
    sticky_d      = sticky_q;
    release_stage = 1'b0;
    lock_loss     = 1'b0;

    case (state_q)
      HOLD: begin
        sys_reset_d = '1;
        ready_d     = 1'b0;
        if (locked_s_q) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s_q) begin
          state_d      = HOLD;
          stable_cnt_d = '0;
        end else if (stable_cnt_q == STABLE_LAST) begin
          stable_cnt_d  = '0;
          release_stage = 1'b1;
        end else begin
          stable_cnt_d = stable_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!locked_s_q) begin
          lock_loss = 1'b1;
        end else if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d     = '0;
          release_stage = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s_q) lock_loss = 1'b1;
      end
      default: state_d = HOLD;
    endcase

    // Shifting left clears the lowest still-asserted domain, so release is strictly ascending.
    if (release_stage) begin
      sys_reset_d = sys_reset_q << 1;
      if (sys_reset_d == '0) begin
        state_d = RUN;
        ready_d = 1'b1;
      end else begin
        state_d = RELEASE;
      end
    end

    if (lock_loss) begin
      state_d     = HOLD;
      sys_reset_d = '1;
      ready_d     = 1'b0;
      gap_cnt_d   = '0;
    end

    // Set has priority over clear when both land on the same edge.
    if (clear_sticky) sticky_d = 1'b0;
    if (lock_loss) begin
      sticky_d = 1'b1;
      if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge global_clock) begin
    if (reset) begin
      state_q       <= HOLD;
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      stable_cnt_q  <= '0;
      gap_cnt_q     <= '0;
      sys_reset_q   <= '1;
      ready_q       <= 1'b0;
      loss_cnt_q    <= '0;
      sticky_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
      stable_cnt_q  <= stable_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      sys_reset_q   <= sys_reset_d;
      ready_q       <= ready_d;
      loss_cnt_q    <= loss_cnt_d;
      sticky_q      <= sticky_d;
    end
  end

  assign sys_reset        = sys_reset_q;
  assign ready            = ready_q;
  assign lock_loss_count  = loss_cnt_q;
  assign lock_lost_sticky = sticky_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumes the PLL lock indicator and the PLL global clock, and produces the design's staged system resets. It synchronises `locked`, requires a continuous stable-lock window, then releases reset domains one at a time at fixed spacing. On any loss of lock it reasserts every reset immediately and records the event. It sits directly downstream of the PLL wrapper and upstream of every clocked subsystem.

## Interface

- `STABLE_CYCLES`, default 1024: consecutive synchronised-lock cycles required before the first release; must be ≥1.
- `STAGES`, default 3: number of independently released reset domains; must be ≥1.
- `STAGE_GAP`, default 16: cycles between successive domain releases; must be ≥1.
- `LOSS_CNT_W`, default 8: width of the lock-loss counter.

Ports:

- `global_clock` in 1: the single clock, taken from the PLL global buffer.
- `reset` in 1: synchronous, active-high.
- `locked` in 1: PLL lock, asynchronous to `global_clock`; passes through a 2-flop synchroniser to give `locked_s`.
- `clear_sticky` in 1: one-cycle pulse that clears `lock_lost_sticky`.
- `sys_reset` out STAGES: active-high reset; bit i drives domain i.
- `ready` out 1: high only in RUN, when all domains are released.
- `lock_loss_count` out LOSS_CNT_W: number of lock losses; saturating.
- `lock_lost_sticky` out 1: set on any counted lock loss.

## Operation

- FSM states: HOLD, STABILIZE, RELEASE, RUN.
- **HOLD**
  - `sys_reset` is all ones; `ready`=0.
  - Moves to STABILIZE on the edge where `locked_s`=1.
- **STABILIZE**
  - Stable counter counts 0..STABLE_CYCLES-1 while `locked_s`=1.
  - If `locked_s`=0: go to HOLD and clear the counter. This is not counted as a loss.
  - When the count completes: go to RELEASE and clear `sys_reset[0]` on the same edge.
- **RELEASE**
  - A gap counter clears `sys_reset[i]` exactly STAGE_GAP cycles after `sys_reset[i-1]`.
  - Bits are cleared in ascending order only.
  - When `sys_reset[STAGES-1]` clears, go to RUN and assert `ready` on the same edge.
  - If STAGES=1: go from STABILIZE straight to RUN, clearing `sys_reset[0]` and asserting `ready` together.
- **RUN**: hold all outputs until `locked_s`=0.
- **Lock loss**: `locked_s`=0 in RELEASE or RUN.
  - Next state is HOLD; `sys_reset` goes to all ones and `ready` to 0 on that edge.
  - `lock_loss_count` increments, saturating at 2^LOSS_CNT_W-1.
  - `lock_lost_sticky` is set.
- **Sticky set/clear**
  - `clear_sticky` clears `lock_lost_sticky`.
  - If a lock loss and `clear_sticky` occur on the same edge, the set wins.
  - `lock_loss_count` is cleared only by `reset`.
- **Reset**: `reset`=1 at any edge, in any state and mid-count.
  - State goes to HOLD; both synchroniser flops go to 0; stable and gap counters go to 0.
  - `sys_reset` = all ones, `ready`=0, `lock_loss_count`=0, `lock_lost_sticky`=0.
  - `reset` dominates `clear_sticky` and `locked`.
- **Lock pulses**: pulses on `locked` shorter than 2 cycles may be missed. Low pulses of 2 or more cycles are always seen in `locked_s`.

## Timing

- Synchroniser latency:
  - `locked` first sampled high at edge n gives `locked_s`=1 after edge n+1.
  - The FSM enters STABILIZE at edge n+2.
- Release schedule, with `locked` held high from edge n:
  - `sys_reset[i]` falls at edge n+2+STABLE_CYCLES+i·STAGE_GAP.
  - `ready` rises with `sys_reset[STAGES-1]`.
- Lock-loss latency:
  - `locked` first sampled low at edge m gives `sys_reset` all ones and `ready`=0 at edge m+2.
  - `lock_loss_count` and `lock_lost_sticky` update on that same edge m+2.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset value of every output: `sys_reset`=all ones, `ready`=0, `lock_loss_count`=0, `lock_lost_sticky`=0.

## Test plan

Scenarios 1–5 use STABLE_CYCLES=8, STAGES=3, STAGE_GAP=4.

1. **Clean bring-up**: `reset` for 2 cycles, then `locked`=1 sampled from edge 0.
   - `sys_reset` goes 111→110 at edge 10, →100 at edge 14, →000 at edge 18.
   - `ready` rises at edge 18; `lock_loss_count`=0.
2. **Lock drop during STABILIZE**: `locked` high for edges 0–5, low for edges 6–7, then high again.
   - `sys_reset` stays 111 throughout; the stable count restarts.
   - First release occurs 8 stable cycles after re-entering STABILIZE.
   - `lock_loss_count`=0 and `lock_lost_sticky`=0.
3. **Lock loss in RUN**: after scenario 1, `locked` goes low, first sampled at edge 30.
   - `sys_reset`=111, `ready`=0, `lock_loss_count`=1 and `lock_lost_sticky`=1 at edge 32.
   - Re-lock repeats the scenario-1 schedule relative to the new rise.
4. **Lock loss mid-RELEASE**: drop `locked` when `sys_reset`=100.
   - All bits go back to 111 two edges later; the count increments.
5. **Sticky and saturation**:
   - With LOSS_CNT_W=2, 5 losses leave `lock_loss_count`=3.
   - `clear_sticky` on the same edge as a loss leaves sticky=1; a `clear_sticky` alone afterwards gives sticky=0 with the count still 3.
6. **Reset mid-RELEASE and STAGES=1**:
   - `reset` asserted mid-RELEASE gives all outputs their reset values on the next edge.
   - Separately, with STAGES=1 and STABLE_CYCLES=4: `sys_reset[0]` falls and `ready` rises at edge 6.
